// File: rtl/current_loop_ctrl.sv
// PI(D) motor current loop: error -> integrate -> duty, one sample per 4-state pass; D term built only with CURR_LOOP_D_TERM_EN.
// Latency 3 cycles strobe-to-duty; no backpressure, strobes arriving while a sample is in flight are dropped.
module current_loop_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [11:0] target_curr,
  input  logic [11:0] avg_curr,
  input  logic        curr_vld,
  input  logic        not_pedaling,
  output logic [11:0] drive_duty,
  output logic        duty_vld
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ERR   = 2'd1,
    INTEG = 2'd2,
    OUT   = 2'd3
  } state_t;

  localparam logic [16:0] INTEG_MAX = 17'h1FFFF;

  state_t             state_q, state_d;
  logic [11:0]        tgt_q, tgt_d;
  logic [11:0]        avg_q, avg_d;
  logic signed [11:0] err_q, err_d;
  logic signed [11:0] p_q, p_d;
  logic [16:0]        integ_q, integ_d;
  logic [11:0]        duty_q, duty_d;
  logic               vld_q, vld_d;

  logic signed [12:0] diff;
  logic signed [11:0] err_sat;
  logic signed [18:0] integ_sum;
  logic [16:0]        integ_clamp;
  logic signed [15:0] d_term;
  logic signed [15:0] duty_sum;
  logic [11:0]        duty_clamp;

  // Both operands are unsigned 12-bit, so the 13-bit difference never wraps.
  always_comb begin
    diff = $signed({1'b0, tgt_q}) - $signed({1'b0, avg_q});
    if (!diff[12] && diff[11]) begin
      err_sat = 12'sh7FF;
    end else if (diff[12] && !diff[11]) begin
      err_sat = 12'sh800;
    end else begin
      err_sat = diff[11:0];
    end
  end

  // Max positive sum is 0x1FFFF + 0x7FF, which fits below bit 18, so bit 18 is a pure sign.
  always_comb begin
    integ_sum = $signed({2'b00, integ_q}) + $signed({{7{err_q[11]}}, err_q});
    if (integ_sum[18]) begin
      integ_clamp = '0;
    end else if (integ_sum[17]) begin
      integ_clamp = INTEG_MAX;
    end else begin
      integ_clamp = integ_sum[16:0];
    end
  end

`ifdef CURR_LOOP_D_TERM_EN
  logic signed [11:0] prev_err_q, prev_err_d;
  logic signed [12:0] d_diff;
  logic signed [12:0] d_shift;

  always_comb begin
    d_diff  = $signed({err_q[11], err_q}) - $signed({prev_err_q[11], prev_err_q});
    d_shift = d_diff >>> 2;
    d_term  = $signed({{3{d_shift[12]}}, d_shift});
  end

  always_comb begin
    prev_err_d = prev_err_q;
    if (state_q == OUT) begin
      prev_err_d = err_q;
    end
    if (not_pedaling) begin
      prev_err_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_err_q <= '0;
    end else begin
      prev_err_q <= prev_err_d;
    end
  end
`else
  always_comb begin
    d_term = '0;
  end
`endif

  always_comb begin
    duty_sum = $signed({{4{p_q[11]}}, p_q}) + $signed({5'b00000, integ_q[16:6]}) + d_term;
    if (duty_sum[15]) begin
      duty_clamp = '0;
    end else if (|duty_sum[14:12]) begin
      duty_clamp = 12'hFFF;
    end else begin
      duty_clamp = duty_sum[11:0];
    end
  end

  always_comb begin
    state_d = state_q;
    tgt_d   = tgt_q;
    avg_d   = avg_q;
    err_d   = err_q;
    p_d     = p_q;
    integ_d = integ_q;
    duty_d  = duty_q;
    vld_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (curr_vld) begin
          tgt_d   = target_curr;
          avg_d   = avg_curr;
          state_d = ERR;
        end
      end
      ERR: begin
        err_d   = err_sat;
        state_d = INTEG;
      end
      INTEG: begin
        integ_d = integ_clamp;
        p_d     = err_q;
        state_d = OUT;
      end
      OUT: begin
        duty_d  = duty_clamp;
        vld_d   = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Inhibit overrides loop state every cycle but lets the sequencer keep pulsing.
    if (not_pedaling) begin
      integ_d = '0;
      duty_d  = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      tgt_q   <= '0;
      avg_q   <= '0;
      err_q   <= '0;
      p_q     <= '0;
      integ_q <= '0;
      duty_q  <= '0;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      tgt_q   <= tgt_d;
      avg_q   <= avg_d;
      err_q   <= err_d;
      p_q     <= p_d;
      integ_q <= integ_d;
      duty_q  <= duty_d;
      vld_q   <= vld_d;
    end
  end

  assign drive_duty = duty_q;
  assign duty_vld   = vld_q;

endmodule

// File: doc/current_loop_ctrl.md
CURRENT_LOOP_CTRL -- requirements
Module: current_loop_ctrl

Interface
REQ-001 SHALL have `clk`: input, 1 bit, system clock, all state on rising edge.
REQ-002 SHALL have `rst_n`: input, 1 bit, reset, asynchronous, active-low.
REQ-003 SHALL have `target_curr`: input, 12 bits, unsigned desired motor current from the assist computation.
REQ-004 SHALL have `avg_curr`: input, 12 bits, unsigned measured (averaged) motor current.
REQ-005 SHALL have `curr_vld`: input, 1 bit, single-cycle strobe marking a new `avg_curr` sample.
REQ-006 SHALL have `not_pedaling`: input, 1 bit, level; when high, drive is inhibited and the loop is cleared.
REQ-007 SHALL have `drive_duty`: output, 12 bits, unsigned registered duty command to the PWM block.
REQ-008 SHALL have `duty_vld`: output, 1 bit, single-cycle pulse marking that `drive_duty` has been updated.

Function
REQ-009 SHALL run an FSM with states IDLE, ERR, INTEG, OUT; reset state is IDLE.
REQ-010 SHALL, in IDLE, on `curr_vld`=1, capture `target_curr` and `avg_curr` and go to ERR; otherwise stay in IDLE.
REQ-011 SHALL, in ERR, register err = `target_curr` − `avg_curr` as 13-bit signed, saturated to 12-bit signed [−2048, +2047], then go to INTEG.
REQ-012 SHALL, in INTEG, update integ = clamp(integ + sign-extended err, 0, 0x1FFFF), held in a 17-bit unsigned register, and register P = err; then go to OUT.
REQ-013 SHALL, in OUT, compute sum = P + integ[16:6] (+ D when enabled) at ≥15-bit signed; `drive_duty` = 0 if sum<0, 0xFFF if sum>0xFFF, else sum; pulse `duty_vld` for exactly one cycle; return to IDLE.
REQ-014 SHALL give a latency of 3 cycles: a strobe sampled at edge N yields `drive_duty` and `duty_vld` valid after edge N+3.
REQ-015 SHALL ignore a `curr_vld` that arrives in ERR, INTEG or OUT (sample dropped, no queuing); a strobe in IDLE coincident with OUT→IDLE return is accepted.
REQ-016 SHALL, while `not_pedaling`=1: hold integ and prev_err at 0, force `drive_duty` to 0 on the next edge, let the FSM continue sequencing, and still pulse `duty_vld` in OUT with value 0.
REQ-017 SHALL hold `drive_duty` between updates; `duty_vld`=0 outside OUT.

Reset
REQ-018 SHALL, on `rst_n`=0 (asynchronous, including mid-sequence), clear FSM→IDLE, err, P, integ, prev_err, `drive_duty`=0, `duty_vld`=0; any in-flight sample is discarded.

Configuration
REQ-019 SHALL, with macro CURR_LOOP_D_TERM_EN defined, add D = (err − prev_err) >>> 2 (arithmetic) to sum in OUT, with prev_err ← err updated in OUT and prev_err=0 after reset.
REQ-020 SHALL, without CURR_LOOP_D_TERM_EN, set D=0, implement no prev_err register, and otherwise behave identically.

Verification
REQ-021 SHALL cover reset: assert `rst_n`=0 mid-INTEG → `drive_duty`=0, `duty_vld`=0 immediately; next strobe processed from integ=0.
REQ-022 SHALL cover a single step: integ=0, target=0x200, avg=0x100, one strobe → after 3 cycles `drive_duty`=0x104 (P=0x100, integ=0x100, I=4), `duty_vld` high 1 cycle (D off).
REQ-023 SHALL cover negative clamp: target=0x000, avg=0x800 → err=−2048, integ stays 0, `drive_duty`=0x000.
REQ-024 SHALL cover saturation: target=0xFFF, avg=0x000, 65 strobes spaced ≥4 cycles → err=0x7FF, integ=0x1FFFF, final `drive_duty`=0xFFE.
REQ-025 SHALL cover inhibit: from integ>0, assert `not_pedaling` → integ=0, `drive_duty`=0; deassert, strobe target=0x200/avg=0x100 → 0x104.
REQ-026 SHALL cover dropped strobe: strobes at cycles 0 and 2 → exactly one `duty_vld`, at cycle 3; a strobe at cycle 4 is accepted.
